// File: rtl/sphere_scan_ctrl.sv
// ----------------------------------------------------------------------------
// sphere_scan_ctrl : scans one ray against an on-chip sphere table, one
// sphere per cycle, returning a hit mask and the lowest hit index.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fixed_point;
  localparam int FP_W    = 32;
  localparam int FP_FRAC = 16;

  // Signed Q16.16
  typedef logic signed [FP_W-1:0] fixed_point_t;
  typedef struct packed {
    logic         ovf;
    fixed_point_t v;
  } fx_res_t;

  function automatic fx_res_t fx_add(input fixed_point_t a, input fixed_point_t b);
    logic [FP_W:0] s;
    s = {a[FP_W-1], a} + {b[FP_W-1], b};
    fx_add.ovf = s[FP_W] ^ s[FP_W-1];
    fx_add.v   = s[FP_W-1:0];
  endfunction

  function automatic fx_res_t fx_sub(input fixed_point_t a, input fixed_point_t b);
    logic [FP_W:0] s;
    s = {a[FP_W-1], a} - {b[FP_W-1], b};
    fx_sub.ovf = s[FP_W] ^ s[FP_W-1];
    fx_sub.v   = s[FP_W-1:0];
  endfunction

  function automatic fx_res_t fx_mul(input fixed_point_t a, input fixed_point_t b);
    logic signed [2*FP_W-1:0] p;
    logic signed [2*FP_W-1:0] q;
    p = $signed({{FP_W{a[FP_W-1]}}, a}) * $signed({{FP_W{b[FP_W-1]}}, b});
    q = p >>> FP_FRAC;
    // Upper bits must be a pure sign extension of the kept result
    fx_mul.ovf = !((&q[2*FP_W-1:FP_W-1]) || !(|q[2*FP_W-1:FP_W-1]));
    fx_mul.v   = q[FP_W-1:0];
  endfunction
endpackage

package vector;
  import fixed_point::*;

  typedef struct packed {
    fixed_point_t x;
    fixed_point_t y;
    fixed_point_t z;
  } vector_t;

  typedef struct packed {
    logic    ovf;
    vector_t v;
  } vec_res_t;

  function automatic vec_res_t vsub(input vector_t a, input vector_t b);
    fx_res_t rx, ry, rz;
    rx = fx_sub(a.x, b.x);
    ry = fx_sub(a.y, b.y);
    rz = fx_sub(a.z, b.z);
    vsub.ovf = rx.ovf | ry.ovf | rz.ovf;
    vsub.v   = '{x: rx.v, y: ry.v, z: rz.v};
  endfunction

  function automatic fx_res_t dot(input vector_t a, input vector_t b);
    fx_res_t mx, my, mz, s0, s1;
    mx = fx_mul(a.x, b.x);
    my = fx_mul(a.y, b.y);
    mz = fx_mul(a.z, b.z);
    s0 = fx_add(mx.v, my.v);
    s1 = fx_add(s0.v, mz.v);
    dot.ovf = mx.ovf | my.ovf | mz.ovf | s0.ovf | s1.ovf;
    dot.v   = s1.v;
  endfunction
endpackage

// Infinite-line / sphere test: hit when r^2 - (|oc|^2 - (oc.l)^2) >= 0.
module sphere (
  input  vector::vector_t            center,
  input  fixed_point::fixed_point_t  radius,
  input  vector::vector_t            origin,
  input  vector::vector_t            direction,
  output logic                       intersects
);
  import fixed_point::*;

  vector::vec_res_t oc;
  fx_res_t tca, oc2, tca2, r2, d2, disc;

  always_comb begin
    oc   = vector::vsub(center, origin);
    tca  = vector::dot(oc.v, direction);
    oc2  = vector::dot(oc.v, oc.v);
    tca2 = fx_mul(tca.v, tca.v);
    r2   = fx_mul(radius, radius);
    d2   = fx_sub(oc2.v, tca2.v);
    disc = fx_sub(r2.v, d2.v);
    intersects = !(oc.ovf | tca.ovf | oc2.ovf | tca2.ovf | r2.ovf | d2.ovf | disc.ovf)
                 && !disc.v[FP_W-1];
  end
endmodule

module sphere_scan_ctrl #(
  parameter  int NUM_SPHERES = 8,
  localparam int IDX_W       = $clog2(NUM_SPHERES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [IDX_W-1:0]           cfg_idx,
  input  vector::vector_t            cfg_center,
  input  fixed_point::fixed_point_t  cfg_radius,
  input  logic                       cfg_enable,
  output logic                       busy,
  input  logic                       ray_valid,
  output logic                       ray_ready,
  input  vector::vector_t            ray_origin,
  input  vector::vector_t            ray_direction,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       res_hit,
  output logic [IDX_W-1:0]           res_idx,
  output logic [NUM_SPHERES-1:0]     res_mask
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           cnt_q, cnt_d;
  logic [NUM_SPHERES-1:0]     mask_q, mask_d;
  vector::vector_t            origin_q, origin_d;
  vector::vector_t            dir_q, dir_d;
  vector::vector_t            center_q [NUM_SPHERES];
  vector::vector_t            center_d [NUM_SPHERES];
  fixed_point::fixed_point_t  radius_q [NUM_SPHERES];
  fixed_point::fixed_point_t  radius_d [NUM_SPHERES];
  logic [NUM_SPHERES-1:0]     en_q, en_d;
  logic                       res_hit_q, res_hit_d;
  logic [IDX_W-1:0]           res_idx_q, res_idx_d;
  logic [NUM_SPHERES-1:0]     res_mask_q, res_mask_d;
  logic                       hit;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_SPHERES-1:0] m);
    lowest_idx = '0;
    for (int i = NUM_SPHERES - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  sphere u_sphere (
    .center     (center_q[cnt_q]),
    .radius     (radius_q[cnt_q]),
    .origin     (origin_q),
    .direction  (dir_q),
    .intersects (hit)
  );

  assign busy      = (state_q == S_SCAN);
  // Held low while rst_n is asserted even though the state already reads IDLE
  assign ray_ready = rst_n && (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign res_hit   = res_hit_q;
  assign res_idx   = res_idx_q;
  assign res_mask  = res_mask_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    origin_d   = origin_q;
    dir_d      = dir_q;
    center_d   = center_q;
    radius_d   = radius_q;
    en_d       = en_q;
    res_hit_d  = res_hit_q;
    res_idx_d  = res_idx_q;
    res_mask_d = res_mask_q;

    if (cfg_we && !busy && (int'(cfg_idx) < NUM_SPHERES)) begin
      center_d[cfg_idx] = cfg_center;
      radius_d[cfg_idx] = cfg_radius;
      en_d[cfg_idx]     = cfg_enable;
    end

    case (state_q)
      S_IDLE: begin
        if (ray_valid && ray_ready) begin
          origin_d = ray_origin;
          dir_d    = ray_direction;
          mask_d   = '0;
          cnt_d    = '0;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        mask_d[cnt_q] = hit & en_q[cnt_q];
        if (cnt_q == IDX_W'(NUM_SPHERES - 1)) begin
          cnt_d      = '0;
          res_mask_d = mask_d;
          res_hit_d  = |mask_d;
          res_idx_d  = lowest_idx(mask_d);
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mask_q     <= '0;
      origin_q   <= '0;
      dir_q      <= '0;
      en_q       <= '0;
      res_hit_q  <= 1'b0;
      res_idx_q  <= '0;
      res_mask_q <= '0;
      for (int i = 0; i < NUM_SPHERES; i++) begin
        center_q[i] <= '0;
        radius_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      origin_q   <= origin_d;
      dir_q      <= dir_d;
      en_q       <= en_d;
      res_hit_q  <= res_hit_d;
      res_idx_q  <= res_idx_d;
      res_mask_q <= res_mask_d;
      center_q   <= center_d;
      radius_q   <= radius_d;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_sphere_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sphere_scan_ctrl : scoreboard bench for sphere_scan_ctrl.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sphere_scan_ctrl;
  localparam int N = 8;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       cfg_we = 1'b0;
  logic [2:0]                 cfg_idx = '0;
  vector::vector_t            cfg_center = '0;
  fixed_point::fixed_point_t  cfg_radius = '0;
  logic                       cfg_enable = 1'b0;
  logic                       busy;
  logic                       ray_valid = 1'b0;
  logic                       ray_ready;
  vector::vector_t            ray_origin = '0;
  vector::vector_t            ray_direction = '0;
  logic                       res_valid;
  logic                       res_ready = 1'b1;
  logic                       res_hit;
  logic [2:0]                 res_idx;
  logic [N-1:0]               res_mask;

  sphere_scan_ctrl #(.NUM_SPHERES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_center(cfg_center),
    .cfg_radius(cfg_radius), .cfg_enable(cfg_enable), .busy(busy),
    .ray_valid(ray_valid), .ray_ready(ray_ready),
    .ray_origin(ray_origin), .ray_direction(ray_direction),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hit(res_hit), .res_idx(res_idx), .res_mask(res_mask)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [N-1:0] sb_q[$];

  // Reference table in integer units
  int m_cx [N], m_cy [N], m_cz [N], m_r [N];
  bit m_en [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic vector::vector_t mkv(input int x, input int y, input int z);
    mkv.x = fixed_point::fixed_point_t'(x * 65536);
    mkv.y = fixed_point::fixed_point_t'(y * 65536);
    mkv.z = fixed_point::fixed_point_t'(z * 65536);
  endfunction

  function automatic logic [2:0] low_idx(input logic [N-1:0] m);
    low_idx = 3'd0;
    for (int i = N - 1; i >= 0; i--) if (m[i]) low_idx = 3'(i);
  endfunction

  // Geometric reference: distance^2 from center to line <= r^2 (l is a unit axis)
  function automatic logic [N-1:0] exp_mask(input int ox, input int oy, input int oz,
                                           input int lx, input int ly, input int lz);
    longint ocx, ocy, ocz, tca, d2;
    exp_mask = '0;
    for (int i = 0; i < N; i++) begin
      ocx = m_cx[i] - ox; ocy = m_cy[i] - oy; ocz = m_cz[i] - oz;
      tca = ocx * lx + ocy * ly + ocz * lz;
      d2  = ocx * ocx + ocy * ocy + ocz * ocz - tca * tca;
      exp_mask[i] = m_en[i] && (d2 <= longint'(m_r[i]) * m_r[i]);
    end
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_cx[i] = 0; m_cy[i] = 0; m_cz[i] = 0; m_r[i] = 0; m_en[i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input int x, input int y, input int z,
                           input int r, input bit en, input bit accept);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_center = mkv(x, y, z);
    cfg_radius = fixed_point::fixed_point_t'(r * 65536); cfg_enable = en;
    tick();
    cfg_we = 1'b0;
    if (accept) begin
      m_cx[idx] = x; m_cy[idx] = y; m_cz[idx] = z; m_r[idx] = r; m_en[idx] = en;
    end
  endtask

  task automatic send_ray(input int ox, input int oy, input int oz,
                          input int lx, input int ly, input int lz);
    int n;
    ray_origin = mkv(ox, oy, oz);
    ray_direction = mkv(lx, ly, lz);
    ray_valid = 1'b1;
    n = 0;
    while (!ray_ready && n < 50) begin tick(); n++; end
    if (!ray_ready) chk("ray_accept_timeout", 32'd0, 32'd1);
    else sb_q.push_back(exp_mask(ox, oy, oz, lx, ly, lz));
    tick();
    ray_valid = 1'b0;
    // Scrambling the inputs after the handshake must not disturb the scan
    ray_origin = mkv(77, -3, 100);
    ray_direction = mkv(0, 1, 0);
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin tick(); n++; end
    if (sb_q.size() != 0) begin
      chk("result_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        chk("res_unexpected", 32'd1, 32'd0);
      end else begin
        logic [N-1:0] e;
        e = sb_q.pop_front();
        chk("res_mask", 32'(res_mask), 32'(e));
        chk("res_hit", 32'(res_hit), 32'(|e));
        chk("res_idx", 32'(res_idx), 32'(low_idx(e)));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_clear();
    // Reset state
    #12;
    chk("rst_ray_ready", 32'(ray_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("idle_ray_ready", 32'(ray_ready), 32'd1);
    chk("idle_res_mask", 32'(res_mask), 32'd0);
    chk("idle_res_hit", 32'(res_hit), 32'd0);
    chk("idle_res_idx", 32'(res_idx), 32'd0);
    tick();

    // Single sphere ahead, with latency check
    cfg_write(0, 0, 0, 5, 1, 1'b1, 1'b1);
    send_ray(0, 0, 0, 0, 0, 1);
    chk("scan_busy", 32'(busy), 32'd1);
    chk("scan_ray_ready", 32'(ray_ready), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("latency_lo", 32'(res_valid), 32'd0);
      tick();
    end
    chk("latency_hi", 32'(res_valid), 32'd1);
    wait_result();

    // Multiple hits plus an off-axis miss
    cfg_write(0, 0, 0, 5, 1, 1'b0, 1'b1);
    cfg_write(2, 0, 0, 5, 1, 1'b1, 1'b1);
    cfg_write(5, 0, 0, 9, 1, 1'b1, 1'b1);
    cfg_write(3, 5, 0, 5, 1, 1'b1, 1'b1);
    send_ray(0, 0, 0, 0, 0, 1);
    wait_result();

    // Behind origin, tangent, and tangent-but-disabled
    cfg_write(1, 0, 0, -5, 1, 1'b1, 1'b1);
    cfg_write(6, 1, 0, 5, 1, 1'b1, 1'b1);
    cfg_write(7, 1, 0, 5, 1, 1'b0, 1'b1);
    send_ray(0, 0, 0, 0, 0, 1);
    wait_result();
    send_ray(0, 0, 0, 1, 0, 0);
    wait_result();
    send_ray(5, 0, 0, 0, 0, 1);
    wait_result();

    // Back-pressure: result held, second ray refused until the handshake
    res_ready = 1'b0;
    send_ray(0, 0, 0, 0, 0, 1);
    n = 0;
    while (!res_valid && n < 20) begin tick(); n++; end
    chk("hold_valid_seen", 32'(res_valid), 32'd1);
    ray_valid = 1'b1;
    ray_origin = mkv(5, 0, 0);
    ray_direction = mkv(0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_res_valid", 32'(res_valid), 32'd1);
      chk("hold_ray_ready", 32'(ray_ready), 32'd0);
      chk("hold_res_mask", 32'(res_mask), 32'(sb_q[0]));
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("hold_popped", 32'(sb_q.size()), 32'd0);
    chk("hold_to_idle", 32'(ray_ready), 32'd1);
    send_ray(5, 0, 0, 0, 0, 1);
    wait_result();

    // Writes while busy are dropped; while idle they take effect
    send_ray(0, 0, 0, 0, 0, 1);
    cfg_write(2, 50, 0, 5, 1, 1'b1, 1'b0);
    wait_result();
    send_ray(0, 0, 0, 0, 0, 1);
    wait_result();
    cfg_write(2, 50, 0, 5, 1, 1'b1, 1'b1);
    send_ray(0, 0, 0, 0, 0, 1);
    wait_result();

    // Write in the same cycle as the ray handshake is seen by that scan
    chk("same_cycle_ready", 32'(ray_ready), 32'd1);
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_center = mkv(0, 0, 7);
    cfg_radius = fixed_point::fixed_point_t'(65536); cfg_enable = 1'b1;
    m_cx[0] = 0; m_cy[0] = 0; m_cz[0] = 7; m_r[0] = 1; m_en[0] = 1'b1;
    ray_origin = mkv(0, 0, 0); ray_direction = mkv(0, 0, 1); ray_valid = 1'b1;
    sb_q.push_back(exp_mask(0, 0, 0, 0, 0, 1));
    tick();
    cfg_we = 1'b0; ray_valid = 1'b0;
    wait_result();

    // Reset in the 4th scan cycle abandons the ray and clears the table
    send_ray(0, 0, 0, 0, 0, 1);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ray_ready", 32'(ray_ready), 32'd0);
    sb_q.delete();
    model_clear();
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("postrst_ray_ready", 32'(ray_ready), 32'd1);
    send_ray(0, 0, 0, 0, 0, 1);
    wait_result();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
